data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port, synchronous-read data memory between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Decodes byte/half/word accesses into big-endian byte-lane write enables and aligns store data.
- Extracts and sign/zero-extends load data one cycle after grant.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- ADDR_BITS, 11, word-address width of the data memory (2048 words).
- BASE_ADDR, 32'h10010000, byte address of memory word 0.
- CPU_PRIORITY, 0, 1 = port 0 always wins contention; 0 = round-robin.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i[p]  in  1  request from port p (p = 0, 1); held with its fields until gnt_o[p].
- wr_i[p]  in  1  1 = store, 0 = load.
- size_i[p]  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- uns_i[p]  in  1  load zero-extend when 1, sign-extend when 0.
- addr_i[p]  in  32  byte address.
- wdata_i[p]  in  32  store data, right-justified.
- gnt_o[p]  out  1  request accepted this cycle (combinational).
- err_o[p]  out  1  with gnt_o: misaligned or out of range, no access made.
- rvalid_o[p]  out  1  load data valid (registered).
- rdata_o  out  32  extended load data, shared by both ports, qualified by rvalid_o.
- mem_en  out  1  memory enable.
- mem_we  out  4  per-byte write enable: we[k] writes byte offset k; byte offset 0 is bits 31:24.
- mem_addr  out  ADDR_BITS  word address.
- mem_wd  out  32  lane-aligned write data.
- mem_rd  in  32  memory read data, valid the cycle after mem_en.

Behaviour:
- Reset state:
  - gnt_o, err_o, rvalid_o, mem_en and mem_we are 0; rdata_o is 0.
  - The round-robin pointer "last" is set to 1, so port 0 wins the first tie.
  - A reset asserted in the cycle after a read grant suppresses that rvalid_o.
- Arbitration (combinational in the request cycle):
  - With one request active, that port is granted.
  - With both active and CPU_PRIORITY = 1, port 0 is granted.
  - With both active and CPU_PRIORITY = 0, the port not equal to "last" is granted, and "last" updates to the granted port.
  - At most one gnt_o is high per cycle. The losing port keeps req_i high and is not granted that cycle.
- Address checks:
  - off = addr - BASE_ADDR; in range iff off < 4·2^ADDR_BITS.
  - Misaligned iff (half and addr[0]) or (word and addr[1:0] != 0).
  - Either fault gives gnt_o = 1 and err_o = 1, with mem_en = 0, mem_we = 0 and no rvalid_o.
- Memory drive on a granted, error-free access:
  - mem_en = 1 and mem_addr = off[ADDR_BITS+1:2].
  - Byte store at offset k: we = one-hot at bit k; data byte placed at bits 31-8k : 24-8k.
  - Half store at offset 0: we = 4'b0011, data in 31:16. At offset 2: we = 4'b1100, data in 15:0.
  - Word store: we = 4'b1111.
  - Loads: we = 0.
- Load pipeline:
  - In the grant cycle, register port, size, uns and the offset bits addr[1:0].
  - In the next cycle, extract the lanes from mem_rd, extend them to 32 bits, and assert rvalid_o[port] for exactly one cycle.
  - Fixed latency is 1 cycle. Grant, extract and extend are all combinational in their respective cycles; there is no stall path.
- Back-to-back: a new grant (either port) is legal in the same cycle as a pending rvalid_o. Throughput is 1 access per cycle.
- Stores complete at gnt_o and return no rvalid_o.
- Store followed by a load to the same word on the next cycle returns the new data; this relies on memory write-then-read ordering across edges.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - function lane_mask(size, off) returning the 4-bit we mask;
  - function load_extract(word, size, off, uns).
- One sub-module, dmem_lane_align: combinational store alignment plus load extraction, instantiated once for the store path and once for the load path.

Test Plan:
- Reset, then port 0 stores word 32'h11223344 at BASE_ADDR -> gnt_o[0] = 1, mem_we = 4'b1111, mem_addr = 0, mem_wd = 32'h11223344, no rvalid_o.
- Loads at BASE+1, each issued after the previous response:
  - byte signed -> next cycle rvalid_o[0] = 1, rdata_o = 32'h00000022;
  - half at BASE+2, unsigned -> rdata_o = 32'h00003344;
  - after storing byte 8'h80 at BASE+3, byte load at BASE+3 signed -> rdata_o = 32'hFFFFFF80.
- Byte store 8'hAB at BASE+2 -> mem_we = 4'b0100, mem_wd[15:8] = 8'hAB. A following word load returns 32'h1122AB44.
- Half load at BASE+1, then word store at BASE+4·2048 -> each gets gnt_o = 1, err_o = 1, mem_en = 0, and no rvalid_o.
- Both ports hold req_i for 4 cycles, CPU_PRIORITY = 0 -> grants 0, 1, 0, 1. With CPU_PRIORITY = 1 -> grants 0, 0, 0, 0.
- Port 0 load grant, rst asserted the next cycle -> rvalid_o stays 0. After release, a tie grants port 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and byte-lane helpers for the data memory arbiter.
// Pure combinational functions; big-endian lanes (byte offset 0 = bits 31:24).
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Context of a granted load, carried into the response cycle.
  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } ld_ctx_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_align(input logic [31:0] wdata, input logic [1:0] size,
                                              input logic [1:0] off);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {wdata[7:0], 24'h0} >> {off, 3'b000};
      SZ_HALF: d = {wdata[15:0], 16'h0} >> {off[1], 4'b0000};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] d;
    // Shift the addressed lane up to the top so the MSB is always sh[31].
    sh = word << {off, 3'b000};
    case (size)
      SZ_BYTE: d = {{24{~uns & sh[31]}}, sh[31:24]};
      SZ_HALF: d = {{16{~uns & sh[31]}}, sh[31:16]};
      default: d = word;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store alignment (LOAD=0) or load extract/extend (LOAD=1).
// Purely combinational, no backpressure.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter bit LOAD = 1'b0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  generate
    if (LOAD) begin : g_load
      assign dout = load_extract(din, size, off, uns);
    end else begin : g_store
      logic unused_uns;
      assign unused_uns = uns;
      assign dout = store_align(din, size, off);
    end
  endgenerate

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter onto a single-port sync-read data memory; grant is combinational,
// load data returns one cycle after grant; losers simply hold req until granted.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int          ADDR_BITS    = 11,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter bit          CPU_PRIORITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_i,
  input  logic [1:0]           wr_i,
  input  logic [1:0][1:0]      size_i,
  input  logic [1:0]           uns_i,
  input  logic [1:0][31:0]     addr_i,
  input  logic [1:0][31:0]     wdata_i,
  output logic [1:0]           gnt_o,
  output logic [1:0]           err_o,
  output logic [1:0]           rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 mem_en,
  output logic [3:0]           mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wd,
  input  logic [31:0]          mem_rd
);

  localparam logic [31:0] SPAN = 32'd4 << ADDR_BITS;

  logic [1:0][31:0] off;
  logic [1:0]       fault;
  logic             last;
  logic             both, any, sel, ok, is_load;
  logic [31:0]      sel_off;
  logic [1:0]       rvalid_q;
  ld_ctx_t          ctx;
  logic [31:0]      ld_data;
  logic             unused_bits;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      off[p]   = addr_i[p] - BASE_ADDR;
      fault[p] = (off[p] >= SPAN) ||
                 ((size_i[p] == SZ_HALF) && addr_i[p][0]) ||
                 (size_i[p][1] && (addr_i[p][1:0] != 2'b00));
    end
  end

  // On a tie, round-robin favours the port that did not win the last tie.
  assign both = &req_i;
  assign any  = (|req_i) & ~rst;
  assign sel  = both ? (CPU_PRIORITY ? 1'b0 : ~last) : req_i[1];

  assign gnt_o   = any ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign err_o   = fault[sel] ? gnt_o : 2'b00;
  assign ok      = any & ~fault[sel];
  assign is_load = ok & ~wr_i[sel];

  assign sel_off     = off[sel];
  assign unused_bits = ^{sel_off[31:ADDR_BITS+2], sel_off[1:0]};

  assign mem_en   = ok;
  assign mem_addr = sel_off[ADDR_BITS+1:2];
  assign mem_we   = (ok & wr_i[sel]) ? lane_mask(size_i[sel], addr_i[sel][1:0]) : 4'b0000;

  dmem_lane_align #(.LOAD(1'b0)) u_store_align (
    .size (size_i[sel]),
    .off  (addr_i[sel][1:0]),
    .uns  (uns_i[sel]),
    .din  (wdata_i[sel]),
    .dout (mem_wd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= 1'b1;
      rvalid_q <= 2'b00;
      ctx      <= '0;
    end else begin
      if (both && !CPU_PRIORITY) begin
        last <= sel;
      end
      rvalid_q <= is_load ? gnt_o : 2'b00;
      if (is_load) begin
        ctx.size <= size_i[sel];
        ctx.uns  <= uns_i[sel];
        ctx.off  <= addr_i[sel][1:0];
      end
    end
  end

  dmem_lane_align #(.LOAD(1'b1)) u_load_extract (
    .size (ctx.size),
    .off  (ctx.off),
    .uns  (ctx.uns),
    .din  (mem_rd),
    .dout (ld_data)
  );

  // Reset in the response cycle kills the in-flight rvalid immediately.
  assign rvalid_o = rst ? 2'b00 : rvalid_q;
  assign rdata_o  = (|rvalid_o) ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed table-driven bench for data_mem_arbiter with a byte-lane memory model;
// a second instance with CPU_PRIORITY=1 shares the stimulus for the fixed-priority tie check.
module tb_data_mem_arbiter;

  localparam logic [31:0] B = 32'h1001_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req, wr, uns;
  logic [1:0][1:0]  size;
  logic [1:0][31:0] addr, wdata;

  logic [1:0]  gnt, err, rvalid;
  logic [31:0] rdata, mem_wd, mem_rd;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [10:0] mem_addr;

  logic [1:0]  p_gnt, p_err, p_rvalid;
  logic [31:0] p_rdata, p_wd;
  logic        p_en;
  logic [3:0]  p_we;
  logic [10:0] p_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_BITS(11), .BASE_ADDR(B), .CPU_PRIORITY(1'b0)) dut (
    .clk(clk), .rst(rst), .req_i(req), .wr_i(wr), .size_i(size), .uns_i(uns),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .err_o(err), .rvalid_o(rvalid),
    .rdata_o(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  data_mem_arbiter #(.ADDR_BITS(11), .BASE_ADDR(B), .CPU_PRIORITY(1'b1)) dut_pri (
    .clk(clk), .rst(rst), .req_i(req), .wr_i(wr), .size_i(size), .uns_i(uns),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(p_gnt), .err_o(p_err), .rvalid_o(p_rvalid),
    .rdata_o(p_rdata), .mem_en(p_en), .mem_we(p_we), .mem_addr(p_addr),
    .mem_wd(p_wd), .mem_rd(32'h0)
  );

  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int k = 0; k < 4; k++)
        if (mem_we[k]) mem[mem_addr][31-8*k -: 8] <= mem_wd[31-8*k -: 8];
      mem_rd <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drv(input int p, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    wr[p]    = w;
    size[p]  = sz;
    uns[p]   = u;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  we;
    logic [10:0] maddr;
    logic [31:0] wmask;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] rdata;
  } vec_t;

  vec_t v [20];

  initial begin
    logic [1:0] eg;
    //        port wr sz    uns addr               wdata         err we       maddr    wmask         wd            rv rdata
    v[0]  = '{0, 1'b1, 2'd2, 1'b0, B,             32'h11223344, 1'b0, 4'b1111, 11'd0,    32'hFFFFFFFF, 32'h11223344, 1'b0, 32'h0};
    v[1]  = '{0, 1'b0, 2'd0, 1'b0, B + 32'd1,     32'h0,        1'b0, 4'b0000, 11'd0,    32'h0,        32'h0,        1'b1, 32'h00000022};
    v[2]  = '{0, 1'b0, 2'd1, 1'b1, B + 32'd2,     32'h0,        1'b0, 4'b0000, 11'd0,    32'h0,        32'h0,        1'b1, 32'h00003344};
    v[3]  = '{0, 1'b1, 2'd0, 1'b0, B + 32'd2,     32'h000000AB, 1'b0, 4'b0100, 11'd0,    32'h0000FF00, 32'h0000AB00, 1'b0, 32'h0};
    v[4]  = '{0, 1'b0, 2'd2, 1'b0, B,             32'h0,        1'b0, 4'b0000, 11'd0,    32'h0,        32'h0,        1'b1, 32'h1122AB44};
    v[5]  = '{0, 1'b1, 2'd0, 1'b0, B + 32'd3,     32'h00000080, 1'b0, 4'b1000, 11'd0,    32'h000000FF, 32'h00000080, 1'b0, 32'h0};
    v[6]  = '{0, 1'b0, 2'd0, 1'b0, B + 32'd3,     32'h0,        1'b0, 4'b0000, 11'd0,    32'h0,        32'h0,        1'b1, 32'hFFFFFF80};
    v[7]  = '{0, 1'b0, 2'd1, 1'b0, B + 32'd1,     32'h0,        1'b1, 4'b0000, 11'd0,    32'h0,        32'h0,        1'b0, 32'h0};
    v[8]  = '{0, 1'b1, 2'd2, 1'b0, B + 32'd8192,  32'hDEADBEEF, 1'b1, 4'b0000, 11'd0,    32'h0,        32'h0,        1'b0, 32'h0};
    v[9]  = '{1, 1'b1, 2'd2, 1'b0, B + 32'd4,     32'hCAFEF00D, 1'b0, 4'b1111, 11'd1,    32'hFFFFFFFF, 32'hCAFEF00D, 1'b0, 32'h0};
    v[10] = '{1, 1'b1, 2'd1, 1'b0, B + 32'd6,     32'h0000BEEF, 1'b0, 4'b1100, 11'd1,    32'h0000FFFF, 32'h0000BEEF, 1'b0, 32'h0};
    v[11] = '{1, 1'b0, 2'd1, 1'b0, B + 32'd6,     32'h0,        1'b0, 4'b0000, 11'd1,    32'h0,        32'h0,        1'b1, 32'hFFFFBEEF};
    v[12] = '{1, 1'b0, 2'd0, 1'b1, B + 32'd4,     32'h0,        1'b0, 4'b0000, 11'd1,    32'h0,        32'h0,        1'b1, 32'h000000CA};
    v[13] = '{0, 1'b0, 2'd0, 1'b0, B + 32'd4,     32'h0,        1'b0, 4'b0000, 11'd1,    32'h0,        32'h0,        1'b1, 32'hFFFFFFCA};
    v[14] = '{0, 1'b0, 2'd0, 1'b0, B - 32'd1,     32'h0,        1'b1, 4'b0000, 11'd0,    32'h0,        32'h0,        1'b0, 32'h0};
    v[15] = '{1, 1'b1, 2'd0, 1'b0, B + 32'd8191,  32'h0000005A, 1'b0, 4'b1000, 11'd2047, 32'h000000FF, 32'h0000005A, 1'b0, 32'h0};
    v[16] = '{0, 1'b0, 2'd3, 1'b0, B + 32'd4,     32'h0,        1'b0, 4'b0000, 11'd1,    32'h0,        32'h0,        1'b1, 32'hCAFEBEEF};
    v[17] = '{1, 1'b0, 2'd3, 1'b0, B + 32'd6,     32'h0,        1'b1, 4'b0000, 11'd0,    32'h0,        32'h0,        1'b0, 32'h0};
    v[18] = '{0, 1'b1, 2'd1, 1'b0, B + 32'd8,     32'h00001234, 1'b0, 4'b0011, 11'd2,    32'hFFFF0000, 32'h12340000, 1'b0, 32'h0};
    v[19] = '{0, 1'b0, 2'd1, 1'b1, B + 32'd8,     32'h0,        1'b0, 4'b0000, 11'd2,    32'h0,        32'h0,        1'b1, 32'h00001234};

    rst = 1'b1; req = 2'b00; wr = 2'b00; uns = 2'b00; size = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst rvalid", 32'(rvalid), 32'h0);
    chk("rst rdata",  rdata,       32'h0);
    chk("rst en",     32'(mem_en), 32'h0);
    chk("rst we",     32'(mem_we), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drv(v[i].port, v[i].wr, v[i].size, v[i].uns, v[i].addr, v[i].wdata);
      req = (v[i].port == 1) ? 2'b10 : 2'b01;
      eg  = req;
      @(negedge clk);
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(eg));
      chk($sformatf("v%0d err", i), 32'(err), v[i].err ? 32'(eg) : 32'h0);
      chk($sformatf("v%0d en", i),  32'(mem_en), 32'(!v[i].err));
      chk($sformatf("v%0d we", i),  32'(mem_we), 32'(v[i].we));
      if (!v[i].err) chk($sformatf("v%0d addr", i), 32'(mem_addr), 32'(v[i].maddr));
      if (v[i].wmask != 32'h0) chk($sformatf("v%0d wd", i), mem_wd & v[i].wmask, v[i].wd);
      @(posedge clk); #1;
      req = 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d rvalid", i), 32'(rvalid), v[i].rv ? 32'(eg) : 32'h0);
      if (v[i].rv) chk($sformatf("v%0d rdata", i), rdata, v[i].rdata);
    end

    // Store then immediate load, then a port 1 load overlapping the pending response.
    @(posedge clk); #1;
    drv(0, 1'b1, 2'd2, 1'b0, B + 32'd8, 32'h55667788); req = 2'b01;
    @(negedge clk);
    chk("b2b st gnt", 32'(gnt), 32'h1);
    chk("b2b st we",  32'(mem_we), 32'hF);
    @(posedge clk); #1;
    drv(0, 1'b0, 2'd2, 1'b0, B + 32'd8, 32'h0);
    @(negedge clk);
    chk("b2b ld0 gnt", 32'(gnt), 32'h1);
    chk("b2b ld0 en",  32'(mem_en), 32'h1);
    @(posedge clk); #1;
    drv(1, 1'b0, 2'd2, 1'b0, B + 32'd4, 32'h0); req = 2'b10;
    @(negedge clk);
    chk("b2b ld1 gnt",  32'(gnt), 32'h2);
    chk("b2b rvalid0",  32'(rvalid), 32'h1);
    chk("b2b rdata0",   rdata, 32'h55667788);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    chk("b2b rvalid1", 32'(rvalid), 32'h2);
    chk("b2b rdata1",  rdata, 32'hCAFEBEEF);

    // Reset with both requests held, then four tie cycles.
    @(posedge clk); #1;
    drv(0, 1'b0, 2'd2, 1'b0, B, 32'h0);
    drv(1, 1'b0, 2'd2, 1'b0, B + 32'd4, 32'h0);
    rst = 1'b1; req = 2'b11;
    @(negedge clk);
    chk("rst2 gnt",     32'(gnt), 32'h0);
    chk("rst2 pri gnt", 32'(p_gnt), 32'h0);
    chk("rst2 en",      32'(mem_en), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("tie rr c%0d", c),  32'(gnt),   (c % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("tie pri c%0d", c), 32'(p_gnt), 32'h1);
      @(posedge clk); #1;
    end
    req = 2'b00;

    // Reset in the response cycle of a load swallows the rvalid.
    @(posedge clk); #1;
    req = 2'b01;
    @(negedge clk);
    chk("sup gnt", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    req = 2'b00; rst = 1'b1;
    @(negedge clk);
    chk("sup rvalid", 32'(rvalid), 32'h0);
    chk("sup rdata",  rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("sup rvalid after", 32'(rvalid), 32'h0);
    @(posedge clk); #1;
    req = 2'b11;
    @(negedge clk);
    chk("post rst tie", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    req = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
